// File: rtl/freq_step_ctrl.sv
// freq_step_ctrl: conditions the Bt_Plus/Bt_Minus push-buttons (sync, debounce, auto-repeat)
// and maintains a saturating frequency index. Define FREQ_WRAP_EN to make the index wrap.
module freq_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYC     = 500000,
  parameter int unsigned REPEAT_DELAY_CYC = 25000000,
  parameter int unsigned REPEAT_RATE_CYC  = 5000000,
  parameter int unsigned IDX_W            = 4,
  parameter int unsigned IDX_MAX          = 15,
  parameter int unsigned IDX_RESET        = 0
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Bt_Plus,
  input  logic             Bt_Minus,
  output logic [IDX_W-1:0] freq_idx,
  output logic             freq_changed,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned N_BTN   = 2;
  localparam int unsigned DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_DELAY,
    ST_REPEAT
  } btn_state_e;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] deb_lvl;
  logic [N_BTN-1:0] step_req;
  logic             lock_q;
  logic             lock_c;
  logic [IDX_W-1:0] idx_d;
  logic             chg_d;

  // Bit 0 is the increment button, bit 1 the decrement button.
  assign btn_raw = {Bt_Minus, Bt_Plus};

  // Lockout is visible in the cycle both buttons first read as pressed.
  assign lock_c = lock_q | (&deb_lvl);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [DB_W-1:0]  db_cnt_q;
    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             step_c;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
      end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        deb_q    <= 1'b0;
        db_cnt_q <= '0;
      end else if (sync2_q == deb_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        deb_q    <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    // Release or lockout wins over any pending step in the same cycle.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      step_c  = 1'b0;
      if (lock_c || !deb_q) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_FIRST;
            tmr_d   = '0;
          end
          ST_FIRST: begin
            step_c  = 1'b1;
            state_d = ST_DELAY;
            tmr_d   = '0;
          end
          ST_DELAY: begin
            if (tmr_q == TMR_W'(REPEAT_DELAY_CYC - 1)) begin
              step_c  = 1'b1;
              state_d = ST_REPEAT;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
          ST_REPEAT: begin
            if (tmr_q == TMR_W'(REPEAT_RATE_CYC - 1)) begin
              step_c = 1'b1;
              tmr_d  = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end
        endcase
      end
    end

    assign deb_lvl[g]  = deb_q;
    assign step_req[g] = step_c;
  end

  // Lockout holds until both debounced levels have returned low.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= (&deb_lvl) | (lock_q & (|deb_lvl));
    end
  end

  // Apply a step; lockout guarantees at most one request per cycle.
  always_comb begin
    idx_d = freq_idx;
    chg_d = 1'b0;
    if (step_req[0]) begin
      if (freq_idx != IDX_W'(IDX_MAX)) begin
        idx_d = freq_idx + IDX_W'(1);
        chg_d = 1'b1;
      end
`ifdef FREQ_WRAP_EN
      else begin
        idx_d = '0;
        chg_d = 1'b1;
      end
`endif
    end else if (step_req[1]) begin
      if (freq_idx != '0) begin
        idx_d = freq_idx - IDX_W'(1);
        chg_d = 1'b1;
      end
`ifdef FREQ_WRAP_EN
      else begin
        idx_d = IDX_W'(IDX_MAX);
        chg_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      freq_idx     <= IDX_W'(IDX_RESET);
      freq_changed <= 1'b0;
      at_max       <= (IDX_RESET == IDX_MAX);
      at_min       <= (IDX_RESET == 0);
    end else begin
      freq_idx     <= idx_d;
      freq_changed <= chg_d;
      at_max       <= (idx_d == IDX_W'(IDX_MAX));
      at_min       <= (idx_d == '0);
    end
  end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// tb_freq_step_ctrl: directed and randomized button stimulus compared each cycle against
// a press-timeline reference model of the controller.
module tb_freq_step_ctrl;

  localparam int unsigned DC   = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RR   = 8;
  localparam int unsigned IW   = 4;
  localparam int unsigned IMAX = 15;
  localparam int unsigned IRST = 0;
  localparam int unsigned HN   = DC + 2;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b0;
  logic          Bt_Plus = 1'b0;
  logic          Bt_Minus = 1'b0;
  logic [IW-1:0] freq_idx;
  logic          freq_changed;
  logic          at_max;
  logic          at_min;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw-level history per button, accepted levels, press timelines.
  bit [HN-1:0]   hist [2];
  bit            m_deb [2];
  bit            m_act [2];
  int            m_start [2];
  bit            m_lock = 1'b0;
  logic [IW-1:0] m_idx = IW'(IRST);
  logic          m_chg = 1'b0;
  int            m_pulses = 0;
  int            dut_pulses = 0;
  int            cyc = 0;

  freq_step_ctrl #(
    .DEBOUNCE_CYC(DC),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC(RR),
    .IDX_W(IW),
    .IDX_MAX(IMAX),
    .IDX_RESET(IRST)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .Bt_Plus(Bt_Plus),
    .Bt_Minus(Bt_Minus),
    .freq_idx(freq_idx),
    .freq_changed(freq_changed),
    .at_max(at_max),
    .at_min(at_min)
  );

  always #5 sysclk = ~sysclk;

  // Steps occur at press age 0, at REPEAT_DELAY, then every REPEAT_RATE.
  function automatic bit step_age(input int a);
    return (a == 0) || (a == int'(RD)) || (a > int'(RD) && ((a - int'(RD)) % int'(RR)) == 0);
  endfunction

  // Drive one cycle of button levels, advance the model, then step past the clock edge.
  task automatic tick(input bit p, input bit m);
    bit raw [2];
    bit stp [2];
    bit lock_now;
    Bt_Plus  = p;
    Bt_Minus = m;
    raw[0] = p;
    raw[1] = m;
    if (reset == 1'b0) begin
      for (int b = 0; b < 2; b++) begin
        hist[b]  = '0;
        m_deb[b] = 1'b0;
        m_act[b] = 1'b0;
      end
      m_lock = 1'b0;
      m_idx  = IW'(IRST);
      m_chg  = 1'b0;
    end else begin
      lock_now = m_lock || (m_deb[0] && m_deb[1]);
      m_chg = 1'b0;
      for (int b = 0; b < 2; b++)
        stp[b] = m_act[b] && m_deb[b] && !lock_now && step_age(cyc - m_start[b]);
      if (stp[0]) begin
        if (m_idx != IW'(IMAX)) begin
          m_idx = m_idx + IW'(1);
          m_chg = 1'b1;
        end
`ifdef FREQ_WRAP_EN
        else begin
          m_idx = '0;
          m_chg = 1'b1;
        end
`endif
      end else if (stp[1]) begin
        if (m_idx != '0) begin
          m_idx = m_idx - IW'(1);
          m_chg = 1'b1;
        end
`ifdef FREQ_WRAP_EN
        else begin
          m_idx = IW'(IMAX);
          m_chg = 1'b1;
        end
`endif
      end
      if (m_chg) m_pulses++;
      for (int b = 0; b < 2; b++) begin
        if (lock_now || !m_deb[b]) m_act[b] = 1'b0;
        else if (!m_act[b]) begin
          m_act[b]   = 1'b1;
          m_start[b] = cyc + 1;
        end
      end
      m_lock = (m_deb[0] && m_deb[1]) || (m_lock && (m_deb[0] || m_deb[1]));
      // Accepted level flips once the synchronised level (2 cycles late) differed for DC cycles.
      for (int b = 0; b < 2; b++) begin
        hist[b] = {hist[b][HN-2:0], raw[b]};
        if (&(hist[b][DC+1:2] ^ {DC{m_deb[b]}})) m_deb[b] = !m_deb[b];
      end
    end
    @(posedge sysclk);
    #1;
    cyc++;
    if (freq_changed === 1'b1) dut_pulses++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    total++;
    if (freq_idx !== IW'(IRST)) begin
      bad++; $display("FAIL reset_idx got=%0d want=%0d", freq_idx, IRST);
    end
    total++;
    if (at_min !== 1'b1) begin
      bad++; $display("FAIL reset_at_min got=%0b want=1", at_min);
    end
    total++;
    if (at_max !== 1'b0) begin
      bad++; $display("FAIL reset_at_max got=%0b want=0", at_max);
    end
    total++;
    if (freq_changed !== 1'b0) begin
      bad++; $display("FAIL reset_changed got=%0b want=0", freq_changed);
    end
  endtask

  task automatic test_tap;
    int p0;
    int lat;
    p0  = dut_pulses;
    lat = -1;
    for (int i = 0; i < 22; i++) begin
      tick(i < 10, 1'b0);
      if (freq_changed === 1'b1 && lat < 0) lat = i + 1;
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL tap cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
    total++;
    if (dut_pulses - p0 != 1) begin
      bad++; $display("FAIL tap_pulses got=%0d want=1", dut_pulses - p0);
    end
    total++;
    if (freq_idx !== IW'(1)) begin
      bad++; $display("FAIL tap_idx got=%0d want=1", freq_idx);
    end
    total++;
    if (lat < 6 || lat > 8) begin
      bad++; $display("FAIL tap_latency got=%0d want=6..8", lat);
    end
  endtask

  task automatic test_glitch;
    int p0;
    logic [IW-1:0] idx0;
    p0   = dut_pulses;
    idx0 = m_idx;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, i < 2);
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL glitch cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
    total++;
    if (dut_pulses != p0) begin
      bad++; $display("FAIL glitch_pulses got=%0d want=0", dut_pulses - p0);
    end
    total++;
    if (freq_idx !== idx0) begin
      bad++; $display("FAIL glitch_idx got=%0d want=%0d", freq_idx, idx0);
    end
  endtask

  task automatic test_auto_repeat;
    int p0;
    int mp0;
    int want_steps;
    do_reset(2);
    p0  = dut_pulses;
    mp0 = m_pulses;
    for (int i = 0; i < 114; i++) begin
      tick(i < 100, 1'b0);
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL repeat cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
    // Press is active for hold-2 ages (same debounce lag on press and release).
    want_steps = 2 + (100 - 2 - int'(RD)) / int'(RR);
    total++;
    if (dut_pulses - p0 != want_steps || m_pulses - mp0 != want_steps) begin
      bad++; $display("FAIL repeat_pulses got=%0d want=%0d", dut_pulses - p0, want_steps);
    end
    total++;
    if (freq_idx !== IW'(want_steps)) begin
      bad++; $display("FAIL repeat_idx got=%0d want=%0d", freq_idx, want_steps);
    end
  endtask

  task automatic test_saturation;
    int p0;
    int mp0;
    int guard;
    guard = 0;
    while (m_idx != IW'(IMAX - 1) && guard < 20) begin
      guard++;
      for (int i = 0; i < 22; i++) begin
        tick(i < 10, 1'b0);
        total++;
        if (freq_idx !== m_idx || freq_changed !== m_chg ||
            at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
          bad++; $display("FAIL sat_tap cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
        end
      end
    end
    p0  = dut_pulses;
    mp0 = m_pulses;
    for (int i = 0; i < 214; i++) begin
      tick(i < 200, 1'b0);
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL sat_hold cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
    total++;
    if (dut_pulses - p0 != m_pulses - mp0) begin
      bad++; $display("FAIL sat_model_pulses got=%0d want=%0d", dut_pulses - p0, m_pulses - mp0);
    end
`ifndef FREQ_WRAP_EN
    total++;
    if (freq_idx !== IW'(IMAX) || at_max !== 1'b1) begin
      bad++; $display("FAIL sat_idx got=%0d at_max=%0b want=%0d at_max=1", freq_idx, at_max, IMAX);
    end
    total++;
    if (dut_pulses - p0 != 1) begin
      bad++; $display("FAIL sat_pulses got=%0d want=1", dut_pulses - p0);
    end
`endif
  endtask

  task automatic test_lockout_reset;
    int p0;
    logic [IW-1:0] idx_lock;
    do_reset(2);
    idx_lock = '0;
    p0 = 0;
    for (int i = 0; i < 100; i++) begin
      tick(i < 70, i >= 30);
      if (i == 49) begin
        idx_lock = freq_idx;
        p0 = dut_pulses;
      end
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL lock cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
    total++;
    if (dut_pulses != p0 || freq_idx !== idx_lock) begin
      bad++; $display("FAIL lock_hold pulses=%0d idx=%0d want pulses=0 idx=%0d", dut_pulses - p0, freq_idx, idx_lock);
    end
    reset = 1'b0;
    #1;
    total++;
    if (freq_idx !== IW'(IRST) || freq_changed !== 1'b0) begin
      bad++; $display("FAIL reset_async idx=%0d chg=%0b want idx=%0d chg=0", freq_idx, freq_changed, IRST);
    end
    repeat (2) tick(1'b0, 1'b1);
    reset = 1'b1;
    p0 = dut_pulses;
    for (int i = 0; i < 54; i++) begin
      tick(1'b0, i < 40);
      total++;
      if (freq_idx !== m_idx || freq_changed !== m_chg ||
          at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
        bad++; $display("FAIL rehold cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
      end
    end
`ifndef FREQ_WRAP_EN
    total++;
    if (dut_pulses != p0 || freq_idx !== '0 || at_min !== 1'b1) begin
      bad++; $display("FAIL rehold_sat pulses=%0d idx=%0d at_min=%0b want 0 0 1", dut_pulses - p0, freq_idx, at_min);
    end
`endif
  endtask

  task automatic test_random;
    int  len;
    int  p0;
    int  mp0;
    bit  p;
    bit  m;
    bit  rs;
    p0  = dut_pulses;
    mp0 = m_pulses;
    for (int s = 0; s < 60; s++) begin
      len = int'($urandom_range(1, 45));
      p   = 1'($urandom_range(0, 1));
      m   = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < len; i++) begin
        reset = !(rs && i < 2);
        tick(p, m);
        total++;
        if (freq_idx !== m_idx || freq_changed !== m_chg ||
            at_max !== (m_idx == IW'(IMAX)) || at_min !== (m_idx == '0)) begin
          bad++; $display("FAIL random cyc=%0d idx=%0d want=%0d chg=%0b want=%0b", cyc, freq_idx, m_idx, freq_changed, m_chg);
        end
      end
      reset = 1'b1;
    end
    total++;
    if (dut_pulses - p0 != m_pulses - mp0) begin
      bad++; $display("FAIL random_pulses got=%0d want=%0d", dut_pulses - p0, m_pulses - mp0);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      hist[b]    = '0;
      m_deb[b]   = 1'b0;
      m_act[b]   = 1'b0;
      m_start[b] = 0;
    end
    test_reset();
    test_tap();
    test_glitch();
    test_auto_repeat();
    test_saturation();
    test_lockout_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
